// File: rtl/aes_frame_ctrl.sv
// aes_frame_ctrl: SPI-framed front end for an AES core.
//   Collects a header, a 128/192/256-bit key and N 128-bit blocks from SPI
//   bytes. It runs each block through the core in turn, then returns a status
//   byte followed by the result blocks.
// Optional feature: `define AES_FRAME_CRC_EN appends a CRC-8 byte
//   (poly 0x07, init 0x00) computed over all result bytes.
// Ports:
//   clk, reset (sync, active-low)
//   cs (active-low frame select), byte_done/rx_byte (SPI byte in), tx_byte (next SPI byte out)
//   core_start/core_mode/core_keylen/core_key/core_block -> AES core
//   core_done/core_result <- AES core
//   busy (not IDLE), frame_done (frame completed pulse), err (header rejected, sticky)
module aes_frame_ctrl #(
  parameter int unsigned NBLK     = 4,
  parameter logic [7:0]  STAT_OK  = 8'h5A,
  parameter logic [7:0]  STAT_ERR = 8'hE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         byte_done,
  input  logic [7:0]   rx_byte,
  output logic [7:0]   tx_byte,
  output logic         core_start,
  output logic         core_mode,
  output logic [1:0]   core_keylen,
  output logic [255:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         frame_done,
  output logic         err
);

  localparam int unsigned IW = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_KEY, S_DATA, S_RUN, S_WAIT, S_SEND, S_ERR
  } state_t;

  state_t        state;
  logic [127:0]  blk_buf [NBLK];
  logic [IW-1:0] nlast;        // N-1 of the accepted frame
  logic [IW-1:0] idx;          // block being stored, processed or sent
  logic [4:0]    kcnt;
  logic [3:0]    bcnt;
  logic          status_pend;  // SEND: tx_byte still holds the status byte

  logic [4:0]    key_last;
  logic [3:0]    nbcnt;
  logic [IW-1:0] nidx;
  logic [7:0]    next_tx;

`ifdef AES_FRAME_CRC_EN
  logic [7:0] crc;
  logic       crc_pend;        // SEND: tx_byte holds the CRC byte

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign busy       = (state != S_IDLE);
  assign core_start = (state == S_RUN);
  assign core_block = blk_buf[idx];

  always_comb begin
    key_last = 5'd31;
    case (core_keylen)
      2'b00:   key_last = 5'd15;
      2'b01:   key_last = 5'd23;
      default: key_last = 5'd31;
    endcase
  end

  // Next result byte pointer for SEND; wraps into the following block.
  always_comb begin
    nbcnt   = bcnt + 4'd1;
    nidx    = (bcnt == 4'hF) ? idx + 1'b1 : idx;
    next_tx = blk_buf[nidx][{~nbcnt, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      nlast       <= '0;
      kcnt        <= '0;
      bcnt        <= '0;
      status_pend <= 1'b0;
      tx_byte     <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      core_key    <= '0;
      core_mode   <= 1'b0;
      core_keylen <= '0;
      for (int unsigned i = 0; i < NBLK; i++) begin
        blk_buf[i] <= '0;
      end
`ifdef AES_FRAME_CRC_EN
      crc      <= '0;
      crc_pend <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      // Deselect aborts everything, including a byte arriving this cycle.
      if (state != S_IDLE && cs) begin
        state   <= S_IDLE;
        tx_byte <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!cs) begin
              state   <= S_HDR;
              err     <= 1'b0;
              tx_byte <= '0;
            end
          end
          S_HDR: begin
            if (byte_done) begin
              if (rx_byte[6:5] == 2'b11 || 32'(rx_byte[4:0]) >= NBLK) begin
                state   <= S_ERR;
                err     <= 1'b1;
                tx_byte <= STAT_ERR;
              end else begin
                state       <= S_KEY;
                core_mode   <= rx_byte[7];
                core_keylen <= rx_byte[6:5];
                nlast       <= rx_byte[IW-1:0];
                core_key    <= '0;
                kcnt        <= '0;
              end
            end
          end
          S_KEY: begin
            if (byte_done) begin
              core_key[{~kcnt, 3'b000} +: 8] <= rx_byte;
              kcnt <= kcnt + 5'd1;
              if (kcnt == key_last) begin
                state <= S_DATA;
                idx   <= '0;
                bcnt  <= '0;
              end
            end
          end
          S_DATA: begin
            if (byte_done) begin
              blk_buf[idx][{~bcnt, 3'b000} +: 8] <= rx_byte;
              bcnt <= bcnt + 4'd1;
              if (bcnt == 4'hF) begin
                if (idx == nlast) begin
                  state <= S_RUN;
                  idx   <= '0;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end
          S_RUN: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (core_done) begin
              blk_buf[idx] <= core_result;
              if (idx == nlast) begin
                state       <= S_SEND;
                tx_byte     <= STAT_OK;
                status_pend <= 1'b1;
`ifdef AES_FRAME_CRC_EN
                crc      <= '0;
                crc_pend <= 1'b0;
`endif
              end else begin
                state <= S_RUN;
                idx   <= idx + 1'b1;
              end
            end
          end
          S_SEND: begin
            if (byte_done) begin
              if (status_pend) begin
                status_pend <= 1'b0;
                tx_byte     <= blk_buf[0][127:120];
                idx         <= '0;
                bcnt        <= '0;
`ifdef AES_FRAME_CRC_EN
              end else if (crc_pend) begin
                crc_pend   <= 1'b0;
                frame_done <= 1'b1;
                tx_byte    <= '0;
                state      <= S_IDLE;
              end else if (idx == nlast && bcnt == 4'hF) begin
                // CRC includes the result byte being consumed now.
                tx_byte  <= crc8(crc, tx_byte);
                crc_pend <= 1'b1;
              end else begin
                crc     <= crc8(crc, tx_byte);
                tx_byte <= next_tx;
                idx     <= nidx;
                bcnt    <= nbcnt;
              end
`else
              end else if (idx == nlast && bcnt == 4'hF) begin
                frame_done <= 1'b1;
                tx_byte    <= '0;
                state      <= S_IDLE;
              end else begin
                tx_byte <= next_tx;
                idx     <= nidx;
                bcnt    <= nbcnt;
              end
`endif
            end
          end
          S_ERR: begin
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
